// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage with a two-flop input synchronizer,
// mid-bit sampling from a clock-count baud generator, a one-entry holding
// register with valid/ready handshake, and single-cycle error pulses.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames with
// even-parity checking. Without it, frames are 8N1 and parity_err stays 0.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state, state_next;
  logic        rx_meta, rx_s;
  logic [15:0] bit_cnt;
  logic [2:0]  phase;
  logic [7:0]  data_sr;
  logic        cnt_clr;
  logic        sample_data;
  logic        stop_done;
  logic        byte_ok;
  logic        commit;
  logic        drop;
`ifdef UART_RX_PARITY_EN
  logic        sample_par;
  logic        par_bad;
`endif

  // Two-flop synchronizer; both stages reset to the idle line level.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state and per-cycle control decode.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    sample_data = 1'b0;
    stop_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (bit_cnt == HALF_LAST) begin
          cnt_clr    = 1'b1;
          // A start bit that is no longer low at its centre is a glitch.
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_cnt == FULL_LAST) begin
          cnt_clr     = 1'b1;
          sample_data = 1'b1;
          if (phase == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_cnt == FULL_LAST) begin
          cnt_clr    = 1'b1;
          sample_par = 1'b1;
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_cnt == FULL_LAST) begin
          cnt_clr    = 1'b1;
          stop_done  = 1'b1;
          state_next = rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_clr = 1'b1;
        // Hold off until the line returns high so a stuck-low line
        // cannot look like an endless stream of start bits.
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

`ifdef UART_RX_PARITY_EN
    byte_ok = stop_done && rx_s && !par_bad;
`else
    byte_ok = stop_done && rx_s;
`endif
    // A commit may reuse the slot in the same cycle the old byte is accepted.
    commit = byte_ok && (!rx_valid || rx_ready);
    drop   = byte_ok && rx_valid && !rx_ready;
  end

  // Baud counter, data-bit phase counter and LSB-first shift register.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      bit_cnt <= '0;
      phase   <= '0;
      data_sr <= '0;
    end else begin
      bit_cnt <= cnt_clr ? '0 : bit_cnt + 16'd1;
      if (state == S_START)  phase <= '0;
      else if (sample_data)  phase <= phase + 3'd1;
      if (sample_data) data_sr <= {rx_s, data_sr[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even-parity check captured at the parity sample, reported at stop time.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (sample_par) par_bad <= ^{data_sr, rx_s};
      parity_err <= stop_done && par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Holding register, handshake and error pulses.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_done && !rx_s;
      overrun   <= drop;
      if (commit) begin
        rx_data  <= data_sr;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver at CLKS_PER_BIT=8.
// Expected bytes are queued as frames are sent and compared on acceptance.
module tb_uart_receiver;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LATENCY = 78 + CPB;
`else
  localparam int LATENCY = 78;
`endif

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int valid_hi = 0;
  int acc_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic valid_q = 1'b0;
  logic [7:0] exp_q[$];

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    start_cyc = cyc;
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = ^d;
    tick(CPB);
`endif
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  // Output monitor and scoreboard, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (rx_valid && !valid_q) rise_cyc = cyc;
    if (rx_valid) valid_hi++;
    valid_q = rx_valid;
    if (frame_err)  fe_cnt++;
    if (overrun)    ov_cnt++;
    if (parity_err) pe_cnt++;
    if (rx_valid && rx_ready) begin
      acc_cnt++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rx_data_sb", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int a0, f0, o0, v0;

    // Reset values.
    tick(4);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    tick(4);

    // Basic frame, latency and one-cycle valid with rx_ready held high.
    valid_hi = 0;
    rise_cyc = 0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(2);
    check("latency", 32'(rise_cyc - start_cyc - 1), 32'(LATENCY));
    check("valid_width", 32'(valid_hi), 32'd1);

    // Short low glitch on the idle line, then a real frame.
    a0 = acc_cnt; f0 = fe_cnt; v0 = valid_hi;
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(2 * CPB);
    check("glitch_valid", 32'(valid_hi - v0), 32'd0);
    check("glitch_frame_err", 32'(fe_cnt - f0), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick(2);
    check("glitch_next_acc", 32'(acc_cnt - a0), 32'd1);

    // Stop bit low followed by a held-low line.
    a0 = acc_cnt; f0 = fe_cnt; v0 = valid_hi;
    send_frame(8'h55, 1'b0);
    uart_rx = 1'b0;
    tick(40);
    uart_rx = 1'b1;
    tick(3 * CPB);
    check("break_frame_err", 32'(fe_cnt - f0), 32'd1);
    check("break_valid", 32'(valid_hi - v0), 32'd0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    tick(2);
    check("break_next_acc", 32'(acc_cnt - a0), 32'd1);

    // Overrun: consumer stalled across two frames.
    o0 = ov_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(2);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_pulse", 32'(ov_cnt - o0), 32'd1);
    rx_ready = 1'b1;
    tick(1);
    check("ovr_drain", 32'(rx_valid), 32'd0);

    // Accept coinciding with the next commit: replace, no overrun.
    rx_ready = 1'b0;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    tick(2);
    o0 = ov_cnt;
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        tick(78);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    check("swap_valid", 32'(rx_valid), 32'd1);
    check("swap_data", 32'(rx_data), 32'h22);
    check("swap_no_ovr", 32'(ov_cnt - o0), 32'd0);
    rx_ready = 1'b1;
    tick(2);

    // Reset during data bit 4 aborts the frame silently.
    a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
    fork
      send_frame(8'hF3, 1'b1);
      begin
        tick(5 * CPB + 2);
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
      end
    join
    tick(2 * CPB);
    check("abort_acc", 32'(acc_cnt - a0), 32'd0);
    check("abort_pulses", 32'(fe_cnt - f0 + ov_cnt - o0), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    tick(2);
    check("abort_next_acc", 32'(acc_cnt - a0), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 0x81 with odd parity bit: parity error, byte discarded.
    v0 = valid_hi; f0 = pe_cnt;
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = (i == 0 || i == 7);
      tick(CPB);
    end
    uart_rx = 1'b1;
    tick(CPB);
    tick(CPB);
    tick(2);
    check("par_err_pulse", 32'(pe_cnt - f0), 32'd1);
    check("par_err_valid", 32'(valid_hi - v0), 32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
